nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that adds two NIBBLES*4-bit operands by time-sharing a single
//  fourbit_adder instance, one nibble per clock, LSB nibble first.
//  - Latches the operands on a start request.
//  - Chains the carry through an internal register.
//  - Reports the full sum and carry-out with a one-cycle done pulse.
//  - Sits between a requesting datapath and the shared 4-bit adder.
// PARAMETERS
//  NIBBLES   4   operand width in nibbles (W = 4*NIBBLES); legal range 1..16
// PORTS
//  clk      in   1   single clock; all state changes on the rising edge
//  rst      in   1   synchronous, active-high reset
//  start    in   1   request; sampled only in IDLE
//  a_in     in   W   operand A; captured on the accepted start
//  b_in     in   W   operand B; captured on the accepted start
//  cin      in   1   carry-in; captured on the accepted start
//  busy     out  1   high in RUN and DONE
//  done     out  1   one-cycle pulse; result valid
//  sum_out  out  W   result register; held until the next done
//  cout     out  1   final carry; held until the next done
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge):
//   - state=IDLE, idx=0, carry_reg=0.
//   - busy=0, done=0, sum_out=0, cout=0.
//   - Work registers are cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: if start=1, capture a_reg<=a_in, b_reg<=b_in, carry_reg<=cin,
//         idx<=0, then go to RUN. If start=0, stay in IDLE.
//   RUN:  the adder sees a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg.
//         Each edge:
//          - adder sum is written to work[4*idx+:4].
//          - carry_reg <= adder carry.
//          - idx <= idx+1.
//         On the edge where idx==NIBBLES-1, go to DONE.
//   DONE: done=1, busy=1.
//         On the DONE->IDLE edge, sum_out<=work and cout<=carry_reg.
//         Unconditional return to IDLE.
//  Result update (resolved):
//   - The work/carry writes happen on the last RUN edge.
//   - In the cycle where done=1, the outputs must already show the new result.
//   - So sum_out and cout are loaded on the last RUN edge (RUN->DONE), from
//     the final adder sum and carry.
//   - They are NOT reloaded on DONE->IDLE.
//  Latency:
//   - Start sampled at edge E0; done is high in the cycle after edge E0+NIBBLES.
//   - Total NIBBLES+1 cycles start-to-done; done is high for exactly one cycle.
//  Handshake:
//   - start is ignored whenever busy=1, including in DONE; no queuing.
//   - A new start is accepted in the first IDLE cycle after DONE.
//   - a_in, b_in and cin are don't-care except on the accepted edge.
//  Arithmetic:
//   - W-bit unsigned addition: {cout,sum_out} = a + b + cin, modulo 2^(W+1).
//   - Wrap-around is reported only via cout.
//  Reset mid-operation:
//   - Aborts the operation immediately; state returns to IDLE.
//   - sum_out and cout return to 0; no done is issued.
//  Simultaneous rst and start: rst wins; start is not captured.
//  idx is $clog2(NIBBLES) bits (min 1); no wrap beyond NIBBLES-1 occurs.
// TESTING
//  1. NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0
//     -> done 5 cycles after start; sum_out=16'h0000, cout=1.
//  2. a=16'h1234, b=16'h4321, cin=1
//     -> sum_out=16'h5556, cout=0; busy high for exactly 5 cycles.
//  3. Run case 2. Pulse start with a=16'hAAAA during RUN and again during DONE
//     -> both ignored; sum_out=16'h5556. A start in the next IDLE cycle is accepted.
//  4. Start a=16'h0F0F, b=16'h00F1; assert rst on the 2nd RUN cycle
//     -> next cycle: busy=0, done=0, sum_out=0, cout=0; no done pulse follows.
//  5. NIBBLES=1, a=4'hF, b=4'h1, cin=1
//     -> done 2 cycles after start; sum_out=4'h1, cout=1.
//  6. Random a/b/cin, 200 back-to-back ops at NIBBLES=4
//     -> each result matches the reference model a+b+cin.
//     -> done pulses exactly one cycle each, 6 cycles apart.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder: one shared 4-bit adder slice is time-shared across the
// operand nibbles (LSB first) with the carry chained through a register.

module fourbit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    assign {c_o, sum_o} = 5'(a_i) + 5'(b_i) + 5'(c_i);
endmodule

module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 cout
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned LAST  = NIBBLES - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       work_q;
    logic [W-1:0]       work_d;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         add_sum;
    logic               add_co;

    // Nibble select and work-register merge using constant slices only
    always_comb begin
        a_nib  = 4'h0;
        b_nib  = 4'h0;
        work_d = work_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib            = a_q[4*i +: 4];
                b_nib            = b_q[4*i +: 4];
                work_d[4*i +: 4] = add_sum;
            end
        end
    end

    fourbit_adder u_adder (
        .a_i   (a_nib),
        .b_i   (b_nib),
        .c_i   (carry_q),
        .sum_o (add_sum),
        .c_o   (add_co)
    );

    // Result is loaded on the last RUN edge so it is visible while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= add_co;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(LAST)) begin
                        sum_q   <= work_d;
                        cout_q  <= add_co;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at NIBBLES=4 and NIBBLES=1.

module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, cin4, busy4, done4, cout4;
    logic [15:0] a4, b4, sum4;
    logic        start1, cin1, busy1, done1, cout1;
    logic [3:0]  a1, b1, sum1;

    int passed = 0;
    int total  = 0;

    logic [16:0] sb4[$];
    logic [4:0]  sb1[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
    );

    function automatic logic [16:0] ref4(input logic [15:0] a, input logic [15:0] b, input logic c);
        return 17'(a) + 17'(b) + 17'(c);
    endfunction

    // Watches ten cycles after a start was driven; start is dropped after one cycle.
    task automatic observe4(output int done_lat, output int busy_cnt, output int done_cnt,
                            output logic [16:0] res);
        done_lat = -1; busy_cnt = 0; done_cnt = 0; res = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            if (busy4) busy_cnt++;
            if (done4) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat = i;
                    res = {cout4, sum4};
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({busy4, done4, cout4, sum4} !== 19'h0) $display("FAIL reset4: got %h exp 0", {busy4, done4, cout4, sum4}); else passed++;
        total++; if ({busy1, done1, cout1, sum1} !== 7'h0) $display("FAIL reset1: got %h exp 0", {busy1, done1, cout1, sum1}); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({busy4, done4} !== 2'b00) $display("FAIL idle_no_start: got %b exp 00", {busy4, done4}); else passed++;
    endtask

    task automatic test_overflow();
        int lat, bc, dc; logic [16:0] res, exp;
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
        sb4.push_back(17'h1_0000);
        observe4(lat, bc, dc, res);
        exp = sb4.pop_front();
        total++; if (lat !== 5) $display("FAIL ovf_latency: got %0d exp 5", lat); else passed++;
        total++; if (res !== exp) $display("FAIL ovf_result: got %h exp %h", res, exp); else passed++;
        total++; if (dc !== 1) $display("FAIL ovf_done_width: got %0d exp 1", dc); else passed++;
    endtask

    task automatic test_add_busy();
        int lat, bc, dc; logic [16:0] res, exp;
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b1; start4 = 1'b1;
        sb4.push_back(17'h0_5556);
        observe4(lat, bc, dc, res);
        exp = sb4.pop_front();
        total++; if (res !== exp) $display("FAIL add_result: got %h exp %h", res, exp); else passed++;
        total++; if (bc !== 5) $display("FAIL busy_cycles: got %0d exp 5", bc); else passed++;
        total++; if (lat !== 5) $display("FAIL add_latency: got %0d exp 5", lat); else passed++;
    endtask

    task automatic test_start_ignored();
        int dones = 0; logic [16:0] exp;
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b1; start4 = 1'b1;
        sb4.push_back(17'h0_5556);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done4) begin
                dones++;
                if (sb4.size() == 0) begin
                    total++; $display("FAIL ignore_spurious_done: got done at %0d exp none", i);
                end else begin
                    exp = sb4.pop_front();
                    total++; if ({cout4, sum4} !== exp) $display("FAIL ignore_result: got %h exp %h", {cout4, sum4}, exp); else passed++;
                end
            end
            if (i == 2 || i == 5) begin
                a4 = 16'hAAAA; b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
            end else if (i == 6) begin
                a4 = 16'h0001; b4 = 16'h0002; cin4 = 1'b0; start4 = 1'b1;
                sb4.push_back(17'h0_0003);
            end else begin
                start4 = 1'b0;
            end
            if (i == 11) begin
                total++; if (done4 !== 1'b1) $display("FAIL ignore_next_latency: got done=%b exp 1 at 11", done4); else passed++;
            end
        end
        total++; if (dones !== 2) $display("FAIL ignore_done_count: got %0d exp 2", dones); else passed++;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        a4 = 16'h0F0F; b4 = 16'h00F1; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++; if ({busy4, done4, cout4, sum4} !== 19'h0) $display("FAIL midrst_outputs: got %h exp 0", {busy4, done4, cout4, sum4}); else passed++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        total++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d exp 0", dones); else passed++;
        rst = 1'b1; start4 = 1'b1; a4 = 16'h5555;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        @(negedge clk);
        total++; if (busy4 !== 1'b0) $display("FAIL rst_beats_start: got busy=%b exp 0", busy4); else passed++;
    endtask

    task automatic test_nibble1();
        int lat; logic [4:0] res, exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; sb1.push_back(5'h11); end
            else        begin a1 = 4'h7; b1 = 4'h8; cin1 = 1'b0; sb1.push_back(5'h0F); end
            start1 = 1'b1;
            lat = -1; res = '0;
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk);
                if (i == 1) start1 = 1'b0;
                if (done1 && lat < 0) begin lat = i; res = {cout1, sum1}; end
            end
            exp = sb1.pop_front();
            total++; if (lat !== 2) $display("FAIL n1_latency%0d: got %0d exp 2", k, lat); else passed++;
            total++; if (res !== exp) $display("FAIL n1_result%0d: got %h exp %h", k, res, exp); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int last_done = -1; int dones = 0; logic [16:0] exp;
        for (int t = 0; t <= 1210; t++) begin
            @(negedge clk);
            if (done4) begin
                if (sb4.size() == 0) begin
                    total++; $display("FAIL b2b_spurious_done: got done at %0d exp none", t);
                end else begin
                    exp = sb4.pop_front();
                    total++; if ({cout4, sum4} !== exp) $display("FAIL b2b_result: got %h exp %h", {cout4, sum4}, exp); else passed++;
                end
                if (last_done >= 0) begin
                    total++; if (t - last_done != 6) $display("FAIL b2b_spacing: got %0d exp 6", t - last_done); else passed++;
                end
                last_done = t;
                dones++;
            end
            if (t < 1200 && t % 6 == 0) begin
                a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom_range(0, 1));
                start4 = 1'b1;
                sb4.push_back(ref4(a4, b4, cin4));
            end else if (t == 1200) begin
                start4 = 1'b0;
            end
        end
        total++; if (dones !== 200) $display("FAIL b2b_count: got %0d exp 200", dones); else passed++;
        total++; if (sb4.size() !== 0) $display("FAIL b2b_leftover: got %0d exp 0", sb4.size()); else passed++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_overflow();
        test_add_busy();
        test_start_ignored();
        test_reset_mid();
        test_nibble1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
